// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order word fetches, buffers returned instructions with their PCs,
// and flushes buffered and in-flight work on a redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int          OW        = $clog2(MAX_OUTSTANDING + 1);
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] DEPTH_U   = 32'(FIFO_DEPTH);
    localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUTSTANDING);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [OW-1:0] live;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic [31:0]   buf_pc    [FIFO_DEPTH];
    logic [31:0]   credit_used;
    logic [31:0]   redirect_target;
    logic          req_fire;
    logic          push;
    logic          pop;

    // Credits count both buffered entries and live in-flight fetches so a push never overflows.
    assign live            = outstanding - drop_cnt;
    assign credit_used     = 32'(live) + 32'(fifo_count);
    assign req_valid       = !rst && !redirect_valid && (credit_used < DEPTH_U)
                             && (32'(outstanding) < MAX_OUT_U);
    assign req_addr        = fetch_pc;
    assign req_fire        = req_valid && req_ready;
    assign push            = rsp_valid && (drop_cnt == '0);
    assign pop             = instr_valid && instr_ready;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? buf_instr[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                fetch_pc   <= redirect_target;
                rsp_pc     <= redirect_target;
                drop_cnt   <= outstanding - OW'(rsp_valid);
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && push) begin
            buf_instr[wr_ptr] <= rsp_data;
            buf_pc[wr_ptr]    <= rsp_pc;
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !redirect_valid && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against an
// in-order memory model and a PC-stream scoreboard.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat_fixed = 1;
    bit rdy_rand = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    logic [31:0] exp_pc, exp_req, prev_i, prev_p;
    bit          after_redir, prev_stall;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({2'b00, a[31:2]} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: in-order responses, latency >= 1 cycle, cleared by the shared reset.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend.delete();
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end
            if (req_valid && req_ready) begin
                pend.push_back('{req_addr, cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4)))});
                n_cmp++;
                if (pend.size() > 2) begin
                    n_bad++;
                    $display("FAIL in_flight: got %0d want <= 2", pend.size());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Scoreboard: after reset or redirect to P, fetches and delivered PCs run P, P+4, ...
    always @(negedge clk) begin
        if (rst) begin
            exp_pc      = 32'h0;
            exp_req     = 32'h0;
            after_redir = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (after_redir) begin
                n_cmp++;
                if (instr_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL flush_empty: got instr_valid=%b want 0", instr_valid);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (instr_valid !== 1'b1 || instr !== prev_i || instr_pc !== prev_p) begin
                    n_bad++;
                    $display("FAIL hold: got v=%b %h@%h want 1 %h@%h",
                             instr_valid, instr, instr_pc, prev_i, prev_p);
                end
            end
            if (redirect_valid) begin
                n_cmp++;
                if (req_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL redirect_noreq: got req_valid=%b want 0", req_valid);
                end
                exp_pc      = {redirect_pc[31:2], 2'b00};
                exp_req     = exp_pc;
                after_redir = 1'b1;
                prev_stall  = 1'b0;
            end else begin
                after_redir = 1'b0;
                if (req_valid && req_ready) begin
                    n_cmp++;
                    if (req_addr !== exp_req) begin
                        n_bad++;
                        $display("FAIL req_addr_seq: got %h want %h", req_addr, exp_req);
                    end
                    exp_req = exp_req + 32'd4;
                end
                if (instr_valid && instr_ready) begin
                    n_cmp++;
                    if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                        n_bad++;
                        $display("FAIL deliver: got %h@%h want %h@%h",
                                 instr, instr_pc, mem_word(exp_pc), exp_pc);
                    end
                    exp_pc = exp_pc + 32'd4;
                end
                prev_stall = instr_valid && !instr_ready;
                prev_i     = instr;
                prev_p     = instr_pc;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        lat_fixed = 1; rdy_rand = 1'b0; instr_ready = 1'b1;
        rst = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        n_cmp++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b0 || req_addr !== 32'h0
            || instr !== 32'h0 || instr_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rv=%b iv=%b ra=%h i=%h pc=%h want 0 0 0 0 0",
                     req_valid, instr_valid, req_addr, instr, instr_pc);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: got req_valid=%b want 1", req_valid);
        end
        next_cycle();
    endtask

    task automatic test_first_fetch();
        lat_fixed = 1; rdy_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL first_c0: got rv=%b ra=%h iv=%b want 1 0 0", req_valid, req_addr, instr_valid);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (req_addr !== 32'h4 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL first_c1: got ra=%h iv=%b want 4 0", req_addr, instr_valid);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            n_bad++;
            $display("FAIL first_c2: got iv=%b %h@%h want 1 %h@0", instr_valid, instr, instr_pc, mem_word(32'h0));
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== mem_word(32'h4)
            || req_valid !== 1'b1 || req_addr !== 32'h8) begin
            n_bad++;
            $display("FAIL first_c3: got iv=%b pc=%h rv=%b ra=%h want 1 4 1 8",
                     instr_valid, instr_pc, req_valid, req_addr);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        lat_fixed = 1; rdy_rand = 1'b0; instr_ready = 1'b0;
        apply_reset();
        repeat (8) next_cycle();
        @(negedge clk);
        n_cmp++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            n_bad++;
            $display("FAIL stall_full: got rv=%b iv=%b pc=%h want 0 1 0", req_valid, instr_valid, instr_pc);
        end
        next_cycle();
        instr_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (instr_pc !== 32'h0 || req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_0: got pc=%h rv=%b want 0 0", instr_pc, req_valid);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || req_valid !== 1'b1 || req_addr !== 32'h8) begin
            n_bad++;
            $display("FAIL drain_1: got iv=%b pc=%h rv=%b ra=%h want 1 4 1 8",
                     instr_valid, instr_pc, req_valid, req_addr);
        end
        next_cycle();
    endtask

    task automatic test_redirect_drop();
        int n;
        lat_fixed = 3; rdy_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        repeat (2) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        next_cycle();
        redirect_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 30);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
            n_bad++;
            $display("FAIL redirect_drop: got v=%b %h@%h want 1 %h@100", instr_valid, instr, instr_pc, mem_word(32'h100));
        end
        next_cycle();
    endtask

    task automatic test_redirect_collide();
        int n;
        lat_fixed = 1; rdy_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        repeat (2) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL collide_setup: got iv=%b rsp=%b want 1 1", instr_valid, rsp_valid);
        end
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL collide_after: got iv=%b rv=%b ra=%h want 0 1 100", instr_valid, req_valid, req_addr);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 30);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            n_bad++;
            $display("FAIL collide_first: got v=%b pc=%h want 1 100", instr_valid, instr_pc);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int n;
        lat_fixed = 1; rdy_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        repeat (3) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL misaligned: got rv=%b ra=%h want 1 100", req_valid, req_addr);
        end
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        next_cycle();
        redirect_pc = 32'h300;
        next_cycle();
        redirect_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 30);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h300 || instr !== mem_word(32'h300)) begin
            n_bad++;
            $display("FAIL back_to_back: got v=%b %h@%h want 1 %h@300", instr_valid, instr, instr_pc, mem_word(32'h300));
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        lat_fixed = 1; rdy_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_top: got rv=%b ra=%h want 1 fffffffc", req_valid, req_addr);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_zero: got rv=%b ra=%h want 1 0", req_valid, req_addr);
        end
        repeat (6) next_cycle();
    endtask

    task automatic test_random();
        lat_fixed = 0; rdy_rand = 1'b1;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            rst            = ($urandom_range(0, 499) == 0);
            next_cycle();
        end
        rst = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1; rdy_rand = 1'b0;
        repeat (20) next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_drop();
        test_redirect_collide();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of decode and immediate generation.
- Issues in-order word requests to instruction memory and buffers the returned instructions with their PCs in a small FIFO.
- Presents instr/instr_pc to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target, e.g. PC + ImmExt) that flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum in-flight memory requests (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  output  1  fetch request valid.
- req_ready  input  1  memory accepts request.
- req_addr  output  32  word-aligned fetch address.
- rsp_valid  input  1  response valid; in order, no backpressure.
- rsp_data  input  32  instruction word.
- redirect_valid  input  1  one-cycle redirect pulse.
- redirect_pc  input  32  redirect target.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode consumes head.
- instr  output  32  head instruction.
- instr_pc  output  32  PC of head instruction.

Behaviour:
- Reset: fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty. Outputs: req_valid=0, req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Reset mid-operation clears everything; the memory shares rst, so no pre-reset responses arrive afterwards.
- live = outstanding - drop_cnt.
- req_valid = !rst && !redirect_valid && (live + fifo_count < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING).
  - The combinational path from redirect_valid is permitted.
  - req_addr = fetch_pc.
- Request handshake (req_valid && req_ready): fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstanding += 1.
- Response (rsp_valid): outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and discard the data.
  - Otherwise push {rsp_pc, rsp_data}, then rsp_pc += 4.
  - The credit rule guarantees no push into a full FIFO. An overflow is a protocol error and an assertion must fire.
- Simultaneous request handshake and response in one cycle: outstanding unchanged.
- Output latency: a response accepted at edge N appears on instr/instr_pc with instr_valid=1 after edge N (earliest consumption in cycle N+1). There is no bypass path.
- Pop on instr_valid && instr_ready. Push and pop are allowed in the same cycle, including when the FIFO is full.
- instr and instr_pc hold their value while instr_valid=1 and instr_ready=0.
- Redirect (redirect_valid=1), which has priority over all other updates in that cycle:
  - fetch_pc <= {redirect_pc[31:2],2'b00} and rsp_pc <= same value; low bits are silently forced to 00.
  - FIFO cleared, including any same-cycle push or pop; instr_valid=0 next cycle.
  - drop_cnt <= outstanding - rsp_valid. Every in-flight response is discarded, the same-cycle response included.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the latest redirect wins; drop_cnt is recomputed each time.
- Widths: outstanding and drop_cnt are $clog2(MAX_OUTSTANDING+1) bits; fifo_count is $clog2(FIFO_DEPTH+1) bits.

Test Plan:
- Reset release with req_ready=1 and memory latency 1: req_addr goes 0x0, 0x4, 0x8. instr_pc/instr go 0x0/mem[0], then 0x4/mem[1], in order. instr_valid first rises 2 cycles after the first request handshake.
- Hold instr_ready=0: after 2 entries are buffered, req_valid=0 and the FIFO holds 0x0 and 0x4. Raising instr_ready drains one entry per cycle and fetching resumes at 0x8.
- Redirect to 0x100 with 2 requests outstanding: both responses are dropped, the FIFO is flushed, and the next instr_pc is 0x100 with data mem[0x40].
- Redirect coinciding with rsp_valid and a pop: the response is dropped, instr_valid=0 next cycle, and the next issued req_addr=0x100.
- redirect_pc=0x103: req_addr=0x100. Redirects on consecutive cycles to 0x200 then 0x300: the first instr_pc delivered is 0x300.
- fetch_pc=0xFFFF_FFFC: the next req_addr wraps to 0x0000_0000.
